aes_round_ctrl: RTL and testbench

- Sequencing controller for the AES-128 datapath that sits behind the AHB slave.
- Accepts one command at a time from the bus-side logic: key load or block encrypt.
- For key load: drives key expansion and round-key SRAM writes.
- For encrypt: drives the 11-pass round datapath, including mux selects, state-register enables and round-key read addresses.
- Reports completion with a held done/ack handshake.
- Contains no datapath of its own; control only.

---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_rcon_gen.sv | 33 +++
 rtl/aes_round_ctrl.sv | 149 ++++++++++++++
 tb/tb_aes_round_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES-128 round sequencing controller.
package aes_pkg;

    localparam int unsigned AES_NR = 10;

    localparam logic CMD_KEY_LOAD = 1'b0;
    localparam logic CMD_ENCRYPT  = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StKexp = 2'd1,
        StEnc  = 2'd2,
        StDone = 2'd3
    } ctrl_state_t;

    typedef enum logic [1:0] {
        RoundInit  = 2'd0,
        RoundMid   = 2'd1,
        RoundFinal = 2'd2
    } round_sel_t;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: loads 8'h01 or advances by xtime on request.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       step_i,
    output logic [7:0] rcon_o
);

    logic [7:0] rcon_d, rcon_q;

    always_comb begin
        rcon_d = rcon_q;
        if (load_i) begin
            rcon_d = 8'h01;
        end else if (step_i) begin
            rcon_d = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rcon_q <= 8'h00;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for AES-128 key expansion and block encryption; drives the datapath
// strobes and round-key SRAM addressing, and reports completion via done/done_ack.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR      = AES_NR,
    parameter int unsigned KADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic               cmd_op,
    output logic               cmd_ready,
    output logic               key_valid,
    output logic               keyexp_en,
    output logic [7:0]         rcon,
    output logic               key_wr_en,
    output logic [KADDR_W-1:0] key_addr,
    output logic               state_load,
    output logic               state_en,
    output logic [1:0]         round_sel,
    output logic               done,
    output logic               err,
    input  logic               done_ack
);

    localparam int unsigned CntW = $clog2(NR + 2);
    localparam logic [CntW-1:0] CntLast  = CntW'(NR);
    localparam logic [CntW-1:0] CntFinal = CntW'(NR + 1);

    ctrl_state_t     state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic            key_valid_d, key_valid_q;
    logic            err_d, err_q;
    logic            rcon_load, rcon_step;
    logic [7:0]      rcon_raw;
    round_sel_t      round_sel_w;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_valid_d = key_valid_q;
        err_d       = err_q;
        rcon_load   = 1'b0;
        rcon_step   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (cmd_op == CMD_KEY_LOAD) begin
                        state_d     = StKexp;
                        key_valid_d = 1'b0;
                    end else if (key_valid_q) begin
                        state_d = StEnc;
                    end else begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StKexp: begin
                // Preload 01 during the raw-key write so step 1 sees it.
                rcon_load = (cnt_q == '0);
                rcon_step = (cnt_q != '0);
                if (cnt_q == CntLast) begin
                    state_d     = StDone;
                    key_valid_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StEnc: begin
                if (cnt_q == CntFinal) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (done_ack) begin
                    state_d = StIdle;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
        end
    end

    aes_rcon_gen u_rcon_gen (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (rcon_load),
        .step_i (rcon_step),
        .rcon_o (rcon_raw)
    );

    always_comb begin
        keyexp_en   = 1'b0;
        key_wr_en   = 1'b0;
        key_addr    = '0;
        state_load  = 1'b0;
        state_en    = 1'b0;
        round_sel_w = RoundInit;
        unique case (state_q)
            StKexp: begin
                key_wr_en = 1'b1;
                keyexp_en = (cnt_q != '0);
                key_addr  = KADDR_W'(cnt_q);
            end
            StEnc: begin
                // Address runs one cycle ahead of the round that consumes it.
                key_addr   = (cnt_q > CntLast) ? KADDR_W'(NR) : KADDR_W'(cnt_q);
                state_en   = (cnt_q != '0);
                state_load = (cnt_q == CntW'(1));
                if (cnt_q == CntFinal) begin
                    round_sel_w = RoundFinal;
                end else if (cnt_q >= CntW'(2)) begin
                    round_sel_w = RoundMid;
                end
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state_q == StIdle);
    assign done      = (state_q == StDone);
    assign err       = (state_q == StDone) && err_q;
    assign key_valid = key_valid_q;
    assign rcon      = keyexp_en ? rcon_raw : 8'h00;
    assign round_sel = round_sel_w;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: reset, key load, encrypt, handshake and abort cases.
module tb_aes_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_op;
    logic       cmd_ready;
    logic       key_valid;
    logic       keyexp_en;
    logic [7:0] rcon;
    logic       key_wr_en;
    logic [3:0] key_addr;
    logic       state_load;
    logic       state_en;
    logic [1:0] round_sel;
    logic       done;
    logic       err;
    logic       done_ack;

    int total = 0;
    int bad   = 0;

    // {cmd_ready, key_wr_en, keyexp_en, state_en, state_load, done, err}
    logic [6:0] flags;
    assign flags = {cmd_ready, key_wr_en, keyexp_en, state_en, state_load, done, err};

    always #5 clk = ~clk;

    aes_round_ctrl #(
        .NR      (10),
        .KADDR_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_ready  (cmd_ready),
        .key_valid  (key_valid),
        .keyexp_en  (keyexp_en),
        .rcon       (rcon),
        .key_wr_en  (key_wr_en),
        .key_addr   (key_addr),
        .state_load (state_load),
        .state_en   (state_en),
        .round_sel  (round_sel),
        .done       (done),
        .err        (err),
        .done_ack   (done_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; done_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (flags !== 7'b100_0000) begin
            bad++;
            $display("FAIL reset_flags: got %b want %b", flags, 7'b100_0000);
        end
        total++;
        if ({key_valid, rcon, round_sel} !== 11'd0) begin
            bad++;
            $display("FAIL reset_regs: got kv=%b rcon=%h sel=%0d want 0", key_valid, rcon,
                     round_sel);
        end
    endtask

    task automatic test_key_load();
        logic [7:0] rc [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h1b, 8'h36};
        cmd_valid = 1'b1; cmd_op = 1'b0;
        tick();
        cmd_valid = 1'b0; cmd_op = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            total++;
            if (flags !== {2'b01, (i != 0), 4'b0000}) begin
                bad++;
                $display("FAIL kexp_flags[%0d]: got %b want %b", i, flags,
                         {2'b01, (i != 0), 4'b0000});
            end
            total++;
            if (key_addr !== 4'(i) || rcon !== rc[i] || key_valid !== 1'b0) begin
                bad++;
                $display("FAIL kexp_addr_rcon[%0d]: got addr=%0d rcon=%h kv=%b want %0d %h 0",
                         i, key_addr, rcon, key_valid, i, rc[i]);
            end
            tick();
        end
        total++;
        if (flags !== 7'b000_0010 || key_valid !== 1'b1) begin
            bad++;
            $display("FAIL kexp_done: got flags=%b kv=%b want 0000010 1", flags, key_valid);
        end
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        total++;
        if (flags !== 7'b100_0000 || key_valid !== 1'b1) begin
            bad++;
            $display("FAIL kexp_ack: got flags=%b kv=%b want 1000000 1", flags, key_valid);
        end
    endtask

    task automatic test_encrypt();
        logic [3:0] ea;
        logic [1:0] es;
        cmd_valid = 1'b1; cmd_op = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i <= 11; i++) begin
            ea = (i > 10) ? 4'd10 : 4'(i);
            es = (i == 11) ? 2'd2 : ((i >= 2) ? 2'd1 : 2'd0);
            total++;
            if (flags !== {3'b000, (i != 0), (i == 1), 2'b00}) begin
                bad++;
                $display("FAIL enc_flags[%0d]: got %b want %b", i, flags,
                         {3'b000, (i != 0), (i == 1), 2'b00});
            end
            total++;
            if (key_addr !== ea || round_sel !== es) begin
                bad++;
                $display("FAIL enc_addr_sel[%0d]: got addr=%0d sel=%0d want %0d %0d", i,
                         key_addr, round_sel, ea, es);
            end
            // Busy pulses of either opcode must be ignored.
            cmd_valid = i[0];
            cmd_op    = i[1];
            tick();
        end
        cmd_valid = 1'b1; cmd_op = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (flags !== 7'b000_0010 || key_valid !== 1'b1) begin
                bad++;
                $display("FAIL enc_hold[%0d]: got flags=%b kv=%b want 0000010 1", i, flags,
                         key_valid);
            end
            tick();
        end
        cmd_valid = 1'b0;
        done_ack  = 1'b1;
        tick();
        done_ack = 1'b0;
        total++;
        if (flags !== 7'b100_0000) begin
            bad++;
            $display("FAIL enc_ack: got %b want 1000000", flags);
        end
    endtask

    task automatic test_back_to_back();
        // done_ack held high throughout: ignored while busy, honoured on first DONE cycle.
        done_ack  = 1'b1;
        cmd_valid = 1'b1; cmd_op = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            total++;
            if (done !== 1'b0 || cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL b2b_busy[%0d]: got done=%b ready=%b want 0 0", i, done,
                         cmd_ready);
            end
            tick();
        end
        total++;
        if (flags !== 7'b000_0010) begin
            bad++;
            $display("FAIL b2b_done: got %b want 0000010", flags);
        end
        tick();
        done_ack = 1'b0;
        total++;
        if (flags !== 7'b100_0000) begin
            bad++;
            $display("FAIL b2b_idle: got %b want 1000000", flags);
        end
    endtask

    task automatic test_reset_mid_kexp();
        cmd_valid = 1'b1; cmd_op = 1'b0;
        tick();
        cmd_valid = 1'b0;
        total++;
        if (key_valid !== 1'b0 || key_wr_en !== 1'b1) begin
            bad++;
            $display("FAIL reload_clear: got kv=%b wr=%b want 0 1", key_valid, key_wr_en);
        end
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (key_addr !== 4'd5 || rcon !== 8'h10) begin
            bad++;
            $display("FAIL mid_kexp: got addr=%0d rcon=%h want 5 10", key_addr, rcon);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (flags !== 7'b100_0000 || key_valid !== 1'b0 || rcon !== 8'h00) begin
            bad++;
            $display("FAIL abort: got flags=%b kv=%b rcon=%h want 1000000 0 00", flags,
                     key_valid, rcon);
        end
    endtask

    task automatic test_refused_encrypt();
        cmd_valid = 1'b1; cmd_op = 1'b1;
        tick();
        cmd_valid = 1'b0;
        total++;
        if (flags !== 7'b000_0011) begin
            bad++;
            $display("FAIL refused: got %b want 0000011", flags);
        end
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        total++;
        if (flags !== 7'b100_0000) begin
            bad++;
            $display("FAIL refused_ack: got %b want 1000000", flags);
        end
    endtask

    initial begin
        test_reset();
        test_key_load();
        test_encrypt();
        test_back_to_back();
        test_reset_mid_kexp();
        test_refused_encrypt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
